// File: rtl/rca_4bit.sv
// rtl/rca_4bit.sv - registered WIDTH-bit ripple-carry adder
//
// Purpose : {cout, s} = a_in + b_in + c_in, computed by a chain of 1-bit
//           full-adder stages and captured on every rising clk edge.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset, clears s and cout
//           a_in   - operand A, unsigned, WIDTH bits
//           b_in   - operand B, unsigned, WIDTH bits
//           c_in   - carry into stage 0
//           s      - registered sum, WIDTH bits
//           cout   - registered carry out of the MSB stage

module rca_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_d;
    logic             cout_q;
    logic             ripple_c;

    // Walk the chain LSB to MSB; ripple_c carries stage i's carry into
    // stage i+1, so the final value is the carry out of the MSB stage.
    always_comb begin
        s_d      = '0;
        ripple_c = c_in;
        for (int i = 0; i < WIDTH; i++) begin
            s_d[i]   = a_in[i] ^ b_in[i] ^ ripple_c;
            ripple_c = (a_in[i] & b_in[i]) | (ripple_c & (a_in[i] ^ b_in[i]));
        end
        cout_d = ripple_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_rca_4bit.sv
// tb/tb_rca_4bit.sv - self-checking bench for rca_4bit

module tb_rca_4bit;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [WIDTH-1:0] s;
    logic             cout;

    int errors;
    int checks;

    rca_4bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, result taken as WIDTH+1 bits.
    function automatic logic [WIDTH:0] ref_sum(input int a, input int b, input int c);
        int total;
        total = a + b + c;
        return total[WIDTH:0];
    endfunction

    task automatic test_reset();
        logic [WIDTH:0] exp_v;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_in = WIDTH'($urandom);
            b_in = WIDTH'($urandom);
            c_in = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({cout, s} !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got cout=%b s=%b, want cout=0 s=0000", i, cout, s);
            end
        end
        @(negedge clk);
        a_in  = 4'b1011;
        b_in  = 4'b0110;
        c_in  = 1'b1;
        rst_n = 1'b1;
        exp_v = ref_sum(11, 6, 1);
        #1;
        checks++;
        if ({cout, s} !== '0) begin
            errors++;
            $display("FAIL reset_release_no_edge: got cout=%b s=%b, want cout=0 s=0000", cout, s);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout, s} !== exp_v) begin
            errors++;
            $display("FAIL reset_first_capture: got %b, want %b", {cout, s}, exp_v);
        end
    endtask

    // Vector table: a, b, c_in, expected {cout, s} straight from the sheet.
    task automatic run_table(input string name, input logic [WIDTH-1:0] ta[],
                             input logic [WIDTH-1:0] tb[], input logic tc[],
                             input logic [WIDTH:0] te[]);
        for (int i = 0; i < ta.size(); i++) begin
            @(negedge clk);
            a_in = ta[i];
            b_in = tb[i];
            c_in = tc[i];
            @(posedge clk);
            #1;
            checks++;
            if ({cout, s} !== te[i]) begin
                errors++;
                $display("FAIL %s[%0d] %b+%b+%b: got cout=%b s=%b, want cout=%b s=%b",
                         name, i, ta[i], tb[i], tc[i], cout, s, te[i][WIDTH], te[i][WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta[] = '{4'b0000, 4'b0100, 4'b0101, 4'b0111};
        logic [WIDTH-1:0] tb[] = '{4'b0101, 4'b0101, 4'b0101, 4'b0111};
        logic             tc[] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [WIDTH:0]   te[] = '{5'b0_0101, 5'b0_1001, 5'b0_1010, 5'b0_1110};
        run_table("directed", ta, tb, tc, te);
    endtask

    task automatic test_carry_out();
        logic [WIDTH-1:0] ta[] = '{4'b1100, 4'b0100, 4'b1111};
        logic [WIDTH-1:0] tb[] = '{4'b0101, 4'b1101, 4'b1101};
        logic             tc[] = '{1'b0, 1'b0, 1'b0};
        logic [WIDTH:0]   te[] = '{5'b1_0001, 5'b1_0001, 5'b1_1100};
        run_table("carry_out", ta, tb, tc, te);
    endtask

    task automatic test_carry_in();
        logic [WIDTH-1:0] ta[] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        logic [WIDTH-1:0] tb[] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
        logic             tc[] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [WIDTH:0]   te[] = '{5'b1_0000, 5'b0_0001, 5'b1_1111, 5'b0_0000};
        run_table("carry_in", ta, tb, tc, te);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a_in = 4'b0111;
        b_in = 4'b0111;
        c_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({cout, s} !== 5'b0_1110) begin
            errors++;
            $display("FAIL mid_reset_pre: got %b, want 01110", {cout, s});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cout, s} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async_clear: got %b, want 00000", {cout, s});
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({cout, s} !== '0) begin
            errors++;
            $display("FAIL mid_reset_no_resurrect: got %b, want 00000", {cout, s});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout, s} !== 5'b0_1110) begin
            errors++;
            $display("FAIL mid_reset_recapture: got %b, want 01110", {cout, s});
        end
    endtask

    // Inputs change every cycle; a queue of expected sums is popped one
    // cycle after each push, so back-to-back throughput is exercised too.
    task automatic test_exhaustive();
        logic [WIDTH:0] expq[$];
        logic [WIDTH:0] exp_v;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    @(negedge clk);
                    a_in = WIDTH'(a);
                    b_in = WIDTH'(b);
                    c_in = 1'(c);
                    expq.push_back(ref_sum(a, b, c));
                    @(posedge clk);
                    #1;
                    exp_v = expq.pop_front();
                    checks++;
                    if ({cout, s} !== exp_v) begin
                        errors++;
                        $display("FAIL exhaustive %0d+%0d+%0d: got %b, want %b", a, b, c, {cout, s}, exp_v);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int ra;
        int rb;
        int rc;
        logic [WIDTH:0] exp_v;
        for (int i = 0; i < 200; i++) begin
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(15, 0));
            rc = int'($urandom_range(1, 0));
            @(negedge clk);
            a_in = WIDTH'(ra);
            b_in = WIDTH'(rb);
            c_in = 1'(rc);
            exp_v = ref_sum(ra, rb, rc);
            @(posedge clk);
            #1;
            checks++;
            if ({cout, s} !== exp_v) begin
                errors++;
                $display("FAIL random[%0d] %0d+%0d+%0d: got %b, want %b", i, ra, rb, rc, {cout, s}, exp_v);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        c_in   = 1'b0;
        #1;
        checks++;
        if ({cout, s} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got %b, want 00000", {cout, s});
        end
        test_reset();
        test_directed();
        test_carry_out();
        test_carry_in();
        test_mid_reset();
        test_exhaustive();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
